// File: rtl/core_seq_ctrl_pkg.sv
// Shared definitions for the multi-cycle core sequencer: widths, reset constants,
// FSM state encoding and halt-cause codes.
package core_seq_ctrl_pkg;

    localparam int          CORE_XLEN     = 32;
    localparam int          CORE_ILEN     = 32;
    localparam logic [31:0] CORE_RESET_PC = 32'h8000_0000;
    localparam logic [31:0] CORE_NOP      = 32'h0000_0013;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_FETCH_REQ  = 3'd1,
        ST_FETCH_WAIT = 3'd2,
        ST_EXEC       = 3'd3,
        ST_HALT       = 3'd4
    } seq_state_e;

    localparam logic [2:0] HALT_NONE     = 3'd0;
    localparam logic [2:0] HALT_EBREAK   = 3'd1;
    localparam logic [2:0] HALT_FAULT    = 3'd2;
    localparam logic [2:0] HALT_TIMEOUT  = 3'd3;
    localparam logic [2:0] HALT_MISALIGN = 3'd4;

endpackage

// File: rtl/core_seq_ctrl_fetch_watchdog.sv
// Fetch watchdog: counts cycles spent fetching, saturating at LIMIT, and flags
// expiry while the count sits at LIMIT.
module core_seq_ctrl_fetch_watchdog #(
    parameter int LIMIT = 255,
    parameter int W     = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + W'(1);
        end
    end

    assign expired = (cnt == W'(LIMIT));

endmodule

// File: rtl/core_seq_ctrl.sv
// Multi-cycle sequencer: owns the PC, fetches over valid/ready, holds the IR for
// IDU/EXU, gates register-file writes and halts on ebreak or fetch problems.
//
//   state       | meaning
//   ------------+-----------------------------------------------
//   IDLE        | one cycle after reset before the first fetch
//   FETCH_REQ   | request pending at pc, waiting for ifu_req_ready
//   FETCH_WAIT  | request accepted, waiting for the response
//   EXEC        | IR valid, waiting for exu_done
//   HALT        | stopped until rst; halt_cause holds the reason
module core_seq_ctrl
    import core_seq_ctrl_pkg::*;
#(
    parameter int              XLEN          = CORE_XLEN,
    parameter int              ILEN          = CORE_ILEN,
    parameter logic [XLEN-1:0] RESET_PC      = XLEN'(CORE_RESET_PC),
    parameter int              FETCH_TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    output logic            ifu_req_valid,
    input  logic            ifu_req_ready,
    output logic [XLEN-1:0] ifu_addr,
    input  logic            ifu_rsp_valid,
    output logic            ifu_rsp_ready,
    input  logic [ILEN-1:0] ifu_rsp_inst,
    input  logic            ifu_rsp_err,
    output logic [ILEN-1:0] inst,
    output logic            ir_valid,
    input  logic            exu_done,
    input  logic            exu_npc_valid,
    input  logic [XLEN-1:0] exu_npc,
    input  logic            is_ebreak,
    output logic            rf_wr_gate,
    output logic            retire,
    output logic [XLEN-1:0] pc,
    output logic            halted,
    output logic [2:0]      halt_cause
);

    seq_state_e      state, state_nx;
    logic [XLEN-1:0] pc_q, pc_nx;
    logic [ILEN-1:0] inst_q, inst_nx;
    logic [2:0]      cause_q, cause_nx;
    logic            wdog_clr, wdog_en, wdog_expired;

    core_seq_ctrl_fetch_watchdog #(
        .LIMIT (FETCH_TIMEOUT)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (wdog_clr),
        .en      (wdog_en),
        .expired (wdog_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            pc_q    <= RESET_PC;
            inst_q  <= ILEN'(CORE_NOP);
            cause_q <= HALT_NONE;
        end else begin
            state   <= state_nx;
            pc_q    <= pc_nx;
            inst_q  <= inst_nx;
            cause_q <= cause_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        pc_nx         = pc_q;
        inst_nx       = inst_q;
        cause_nx      = cause_q;
        ifu_req_valid = 1'b0;
        ifu_rsp_ready = 1'b0;
        ir_valid      = 1'b0;
        rf_wr_gate    = 1'b0;
        retire        = 1'b0;
        halted        = 1'b0;
        wdog_en       = 1'b0;

        case (state)
            ST_IDLE: begin
                state_nx = ST_FETCH_REQ;
            end
            ST_FETCH_REQ: begin
                wdog_en = 1'b1;
                if (pc_q[1:0] != 2'b00) begin
                    state_nx = ST_HALT;
                    cause_nx = HALT_MISALIGN;
                end else begin
                    ifu_req_valid = 1'b1;
                    // Only a response can beat the timeout; a request handshake cannot.
                    if (wdog_expired) begin
                        state_nx = ST_HALT;
                        cause_nx = HALT_TIMEOUT;
                    end else if (ifu_req_ready) begin
                        state_nx = ST_FETCH_WAIT;
                    end
                end
            end
            ST_FETCH_WAIT: begin
                wdog_en       = 1'b1;
                ifu_rsp_ready = 1'b1;
                if (ifu_rsp_valid) begin
                    if (ifu_rsp_err) begin
                        state_nx = ST_HALT;
                        cause_nx = HALT_FAULT;
                    end else begin
                        inst_nx  = ifu_rsp_inst;
                        state_nx = ST_EXEC;
                    end
                end else if (wdog_expired) begin
                    state_nx = ST_HALT;
                    cause_nx = HALT_TIMEOUT;
                end
            end
            ST_EXEC: begin
                ir_valid = 1'b1;
                if (exu_done) begin
                    retire = 1'b1;
                    if (is_ebreak) begin
                        state_nx = ST_HALT;
                        cause_nx = HALT_EBREAK;
                    end else begin
                        rf_wr_gate = 1'b1;
                        pc_nx      = exu_npc_valid ? exu_npc : pc_q + XLEN'(4);
                        state_nx   = ST_FETCH_REQ;
                    end
                end
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        wdog_clr = (state_nx == ST_FETCH_REQ) && (state != ST_FETCH_REQ);

        // A retirement coinciding with reset is discarded, so suppress its strobes.
        if (rst) begin
            retire     = 1'b0;
            rf_wr_gate = 1'b0;
        end
    end

    assign ifu_addr   = pc_q;
    assign pc         = pc_q;
    assign inst       = inst_q;
    assign halt_cause = cause_q;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Self-checking bench for core_seq_ctrl: a fetch/EXU agent driven from tasks, with
// scoreboards of expected fetch addresses and write-gate values per retirement.
module tb_core_seq_ctrl;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam int          TMO    = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ifu_req_valid, ifu_req_ready = 1'b0;
    logic [31:0] ifu_addr;
    logic        ifu_rsp_valid = 1'b0, ifu_rsp_ready;
    logic [31:0] ifu_rsp_inst = 32'h0;
    logic        ifu_rsp_err = 1'b0;
    logic [31:0] inst;
    logic        ir_valid;
    logic        exu_done = 1'b0, exu_npc_valid = 1'b0;
    logic [31:0] exu_npc = 32'h0;
    logic        is_ebreak = 1'b0;
    logic        rf_wr_gate, retire;
    logic [31:0] pc;
    logic        halted;
    logic [2:0]  halt_cause;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int hs_count = 0;
    int retire_count = 0;

    logic [31:0] model_pc;
    logic [31:0] exp_addr_q[$];
    logic        exp_gate_q[$];
    int          retire_cyc_q[$];

    logic        prev_pending = 1'b0;
    logic [31:0] prev_addr    = 32'h0;

    core_seq_ctrl #(
        .XLEN          (32),
        .ILEN          (32),
        .RESET_PC      (RST_PC),
        .FETCH_TIMEOUT (TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ifu_req_valid (ifu_req_valid),
        .ifu_req_ready (ifu_req_ready),
        .ifu_addr      (ifu_addr),
        .ifu_rsp_valid (ifu_rsp_valid),
        .ifu_rsp_ready (ifu_rsp_ready),
        .ifu_rsp_inst  (ifu_rsp_inst),
        .ifu_rsp_err   (ifu_rsp_err),
        .inst          (inst),
        .ir_valid      (ir_valid),
        .exu_done      (exu_done),
        .exu_npc_valid (exu_npc_valid),
        .exu_npc       (exu_npc),
        .is_ebreak     (is_ebreak),
        .rf_wr_gate    (rf_wr_gate),
        .retire        (retire),
        .pc            (pc),
        .halted        (halted),
        .halt_cause    (halt_cause)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard side: every request handshake and retirement is matched to the queues.
    always @(negedge clk) begin
        logic [31:0] ea;
        logic        eg;
        if (!rst) begin
            if (prev_pending) begin
                n_checks++;
                if (ifu_req_valid !== 1'b1 || ifu_addr !== prev_addr)
                    $display("FAIL req_stable: valid=%0b addr=%h, required valid=1 addr=%h", ifu_req_valid, ifu_addr, prev_addr);
                else n_pass++;
            end
            if (ifu_req_valid && ifu_req_ready) begin
                hs_count++;
                n_checks++;
                if (exp_addr_q.size() == 0) begin
                    $display("FAIL fetch_addr: unexpected request at addr=%h, required none", ifu_addr);
                end else begin
                    ea = exp_addr_q.pop_front();
                    if (ifu_addr !== ea) $display("FAIL fetch_addr: addr=%h, required %h", ifu_addr, ea);
                    else n_pass++;
                end
            end
            if (retire) begin
                retire_count++;
                retire_cyc_q.push_back(cyc);
                n_checks++;
                if (exp_gate_q.size() == 0) begin
                    $display("FAIL retire: unexpected retire (gate=%0b), required none", rf_wr_gate);
                end else begin
                    eg = exp_gate_q.pop_front();
                    if (rf_wr_gate !== eg) $display("FAIL rf_wr_gate: gate=%0b at retire, required %0b", rf_wr_gate, eg);
                    else n_pass++;
                end
            end else if (rf_wr_gate) begin
                n_checks++;
                $display("FAIL rf_wr_gate: gate=1 without retire, required 0");
            end
            prev_pending = ifu_req_valid && !ifu_req_ready;
            prev_addr    = ifu_addr;
        end else begin
            prev_pending = 1'b0;
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        ifu_req_ready = 0; ifu_rsp_valid = 0; ifu_rsp_err = 0;
        exu_done = 0; exu_npc_valid = 0; is_ebreak = 0;
        repeat (2) @(posedge clk);
        #1;
        exp_addr_q.delete();
        exp_gate_q.delete();
        model_pc = RST_PC;
        rst = 1'b0;
    endtask

    // Runs one instruction through the fetch/execute handshakes. Starts and ends #1 after a posedge.
    task automatic run_inst(input logic [31:0] iw, input logic err, input int req_stall,
                            input int rsp_delay, input int exu_delay, input logic redir,
                            input logic [31:0] npc, input logic ebrk, input logic abort_rst);
        int guard = 0;
        while (!ifu_req_valid && guard < 20) begin
            @(posedge clk); #1; guard++;
        end
        n_checks++;
        if (!ifu_req_valid) begin
            $display("FAIL req_wait: ifu_req_valid=%0b after %0d cycles, required 1", ifu_req_valid, guard);
            return;
        end
        n_pass++;
        exp_addr_q.push_back(model_pc);
        for (int i = 0; i < req_stall; i++) begin
            ifu_req_ready = 1'b0; @(posedge clk); #1;
        end
        ifu_req_ready = 1'b1; @(posedge clk); #1;
        ifu_req_ready = 1'b0;
        for (int i = 0; i < rsp_delay; i++) begin
            @(posedge clk); #1;
        end
        ifu_rsp_valid = 1'b1; ifu_rsp_inst = iw; ifu_rsp_err = err;
        @(posedge clk); #1;
        ifu_rsp_valid = 1'b0; ifu_rsp_err = 1'b0;
        if (err) return;
        n_checks++;
        if (ir_valid !== 1'b1 || inst !== iw)
            $display("FAIL ir_load: ir_valid=%0b inst=%h, required 1 %h", ir_valid, inst, iw);
        else n_pass++;
        for (int i = 0; i < exu_delay; i++) begin
            @(posedge clk); #1;
        end
        exu_done = 1'b1; exu_npc_valid = redir; exu_npc = npc; is_ebreak = ebrk;
        if (abort_rst) begin
            rst = 1'b1;
            @(negedge clk);
            n_checks++;
            if (retire !== 1'b0 || rf_wr_gate !== 1'b0)
                $display("FAIL rst_retire: retire=%0b gate=%0b under rst, required 0 0", retire, rf_wr_gate);
            else n_pass++;
        end else begin
            exp_gate_q.push_back(!ebrk);
        end
        @(posedge clk); #1;
        exu_done = 1'b0; exu_npc_valid = 1'b0; is_ebreak = 1'b0;
        if (!ebrk && !abort_rst) model_pc = redir ? npc : model_pc + 32'd4;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (pc !== RST_PC || inst !== NOP || ir_valid !== 0 || ifu_req_valid !== 0 || ifu_rsp_ready !== 0 ||
            retire !== 0 || rf_wr_gate !== 0 || halted !== 0 || halt_cause !== 3'd0)
            $display("FAIL reset_values: pc=%h inst=%h irv=%0b rqv=%0b rsr=%0b ret=%0b gate=%0b halt=%0b cause=%0d, required %h %h 0 0 0 0 0 0 0",
                     pc, inst, ir_valid, ifu_req_valid, ifu_rsp_ready, retire, rf_wr_gate, halted, halt_cause, RST_PC, NOP);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (ifu_req_valid !== 1'b1 || ifu_addr !== RST_PC)
            $display("FAIL idle_to_req: valid=%0b addr=%h, required 1 %h", ifu_req_valid, ifu_addr, RST_PC);
        else n_pass++;
    endtask

    task automatic test_sequential();
        int base;
        do_reset();
        base = retire_cyc_q.size();
        run_inst(32'h0010_0093, 0, 0, 0, 0, 0, 32'h0, 0, 0);
        run_inst(32'h0020_0113, 0, 0, 0, 0, 0, 32'h0, 0, 0);
        run_inst(32'h0030_0193, 0, 0, 0, 0, 0, 32'h0, 0, 0);
        n_checks++;
        if (retire_cyc_q.size() - base != 3 || exp_addr_q.size() != 0)
            $display("FAIL seq_count: retires=%0d pending_fetches=%0d, required 3 0", retire_cyc_q.size() - base, exp_addr_q.size());
        else n_pass++;
        n_checks++;
        if (retire_cyc_q.size() >= 3 && retire_cyc_q[$] - retire_cyc_q[$-1] == 3 && retire_cyc_q[$-1] - retire_cyc_q[$-2] == 3)
            n_pass++;
        else
            $display("FAIL seq_cadence: retire gaps=%0d,%0d, required 3,3", retire_cyc_q[$] - retire_cyc_q[$-1], retire_cyc_q[$-1] - retire_cyc_q[$-2]);
        n_checks++;
        if (pc !== 32'h8000_000C) $display("FAIL seq_pc: pc=%h, required 8000000c", pc);
        else n_pass++;
    endtask

    task automatic test_redirect();
        do_reset();
        run_inst(32'h1000_006F, 0, 0, 0, 2, 1, 32'h8000_0100, 0, 0);
        run_inst(32'h0000_0013, 0, 0, 1, 0, 1, 32'h8000_0102, 0, 0);
        ifu_req_ready = 1'b1;
        n_checks++;
        if (ifu_req_valid !== 1'b0 || pc !== 32'h8000_0102)
            $display("FAIL misalign_req: valid=%0b pc=%h, required 0 80000102", ifu_req_valid, pc);
        else n_pass++;
        @(posedge clk); #1;
        ifu_req_ready = 1'b0;
        n_checks++;
        if (halted !== 1'b1 || halt_cause !== 3'd4 || pc !== 32'h8000_0102 || exp_addr_q.size() != 0)
            $display("FAIL misalign_halt: halted=%0b cause=%0d pc=%h pending=%0d, required 1 4 80000102 0",
                     halted, halt_cause, pc, exp_addr_q.size());
        else n_pass++;
    endtask

    task automatic test_stall_fault();
        int hs0, rt0;
        do_reset();
        hs0 = hs_count; rt0 = retire_count;
        run_inst(32'hDEAD_BEEF, 1, 5, 2, 0, 0, 32'h0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (halted !== 1'b1 || halt_cause !== 3'd2 || inst !== NOP || ir_valid !== 1'b0)
            $display("FAIL fault_halt: halted=%0b cause=%0d inst=%h irv=%0b, required 1 2 %h 0", halted, halt_cause, inst, ir_valid, NOP);
        else n_pass++;
        n_checks++;
        if (hs_count - hs0 != 1 || retire_count != rt0)
            $display("FAIL fault_counts: handshakes=%0d retires=%0d, required 1 0", hs_count - hs0, retire_count - rt0);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int c0, guard;
        do_reset();
        guard = 0;
        while (!ifu_req_valid && guard < 20) begin @(posedge clk); #1; guard++; end
        c0 = cyc;
        exp_addr_q.push_back(model_pc);
        ifu_req_ready = 1'b1; @(posedge clk); #1; ifu_req_ready = 1'b0;
        guard = 0;
        while (!halted && guard < 400) begin @(posedge clk); #1; guard++; end
        // wdog reads 0..TMO across TMO+1 fetch cycles; HALT follows the cycle at TMO.
        n_checks++;
        if (halted !== 1'b1 || cyc - c0 != TMO + 1 || halt_cause !== 3'd3)
            $display("FAIL timeout_halt: halted=%0b after=%0d cause=%0d, required 1 %0d 3", halted, cyc - c0, halt_cause, TMO + 1);
        else n_pass++;

        do_reset();
        run_inst(32'h0050_0293, 0, 0, TMO - 1, 0, 0, 32'h0, 0, 0);
        n_checks++;
        if (halted !== 1'b0 || halt_cause !== 3'd0 || pc !== RST_PC + 32'd4)
            $display("FAIL timeout_race: halted=%0b cause=%0d pc=%h, required 0 0 %h", halted, halt_cause, pc, RST_PC + 32'd4);
        else n_pass++;
        run_inst(32'h0060_0313, 0, 0, 0, 0, 0, 32'h0, 0, 0);
    endtask

    task automatic test_ebreak();
        int rt0, hs0;
        do_reset();
        run_inst(32'h0010_0073, 0, 0, 0, 3, 0, 32'h0, 1, 0);
        rt0 = retire_count; hs0 = hs_count;
        n_checks++;
        if (halted !== 1'b1 || halt_cause !== 3'd1 || pc !== RST_PC || inst !== 32'h0010_0073)
            $display("FAIL ebreak_halt: halted=%0b cause=%0d pc=%h inst=%h, required 1 1 %h 00100073", halted, halt_cause, pc, inst, RST_PC);
        else n_pass++;
        ifu_rsp_valid = 1'b1; ifu_rsp_inst = 32'h1234_5678; exu_done = 1'b1; ifu_req_ready = 1'b1;
        n_checks++;
        if (ifu_rsp_ready !== 1'b0 || ifu_req_valid !== 1'b0 || ir_valid !== 1'b0)
            $display("FAIL halt_outputs: rsp_ready=%0b req_valid=%0b ir_valid=%0b, required 0 0 0", ifu_rsp_ready, ifu_req_valid, ir_valid);
        else n_pass++;
        repeat (4) @(posedge clk);
        #1;
        ifu_rsp_valid = 1'b0; exu_done = 1'b0; ifu_req_ready = 1'b0;
        n_checks++;
        if (halted !== 1'b1 || halt_cause !== 3'd1 || pc !== RST_PC || inst !== 32'h0010_0073 ||
            retire_count != rt0 || hs_count != hs0)
            $display("FAIL halt_absorb: halted=%0b cause=%0d pc=%h inst=%h retires=%0d hs=%0d, required 1 1 %h 00100073 0 0",
                     halted, halt_cause, pc, inst, retire_count - rt0, hs_count - hs0, RST_PC);
        else n_pass++;
    endtask

    task automatic test_rst_mid_exec();
        int rt0;
        do_reset();
        run_inst(32'h0010_0093, 0, 0, 0, 0, 0, 32'h0, 0, 0);
        rt0 = retire_count;
        run_inst(32'h0020_0113, 0, 0, 0, 1, 1, 32'h8000_0400, 0, 1);
        n_checks++;
        if (pc !== RST_PC || inst !== NOP || ir_valid !== 0 || ifu_req_valid !== 0 || halted !== 0 ||
            halt_cause !== 3'd0 || retire_count != rt0)
            $display("FAIL rst_mid_exec: pc=%h inst=%h irv=%0b rqv=%0b halted=%0b cause=%0d retires=%0d, required %h %h 0 0 0 0 0",
                     pc, inst, ir_valid, ifu_req_valid, halted, halt_cause, retire_count - rt0, RST_PC, NOP);
        else n_pass++;
        exp_addr_q.delete();
        exp_gate_q.delete();
        model_pc = RST_PC;
        rst = 1'b0;
        run_inst(32'h0070_0393, 0, 0, 0, 0, 0, 32'h0, 0, 0);
        run_inst(32'h0080_0413, 0, 1, 0, 0, 0, 32'h0, 0, 0);
        n_checks++;
        if (pc !== RST_PC + 32'd8 || retire_count - rt0 != 2 || exp_addr_q.size() != 0)
            $display("FAIL rst_resume: pc=%h retires=%0d pending=%0d, required %h 2 0", pc, retire_count - rt0, exp_addr_q.size(), RST_PC + 32'd8);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_redirect();
        test_stall_fault();
        test_timeout();
        test_ebreak();
        test_rst_mid_exec();
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation exceeded time limit, checks=%0d passed=%0d", n_checks, n_pass);
        $fatal(1);
    end

endmodule
